sobolrng_multi: RTL

- Multi-dimension, self-sequencing Sobol random number generator for the stochastic-computing datapath.
- Runs an internal index counter and derives its own one-hot least-significant-zero select. It keeps a writable direction-vector table per dimension.
- Emits NUM_DIM Gray-code-ordered Sobol values per step over a valid/ready handshake, with a period-end flag.
- Replaces per-dimension cores that took an external one-hot select and fixed direction vectors.

---
 rtl/sobolrng_multi.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sobolrng_multi.sv
`default_nettype none
// ============================================================================
//  Module   : sobolrng_multi
//  Purpose  : Self-sequencing multi-dimension Sobol random number generator.
//             An internal index counter selects, at every accepted step, the
//             direction vector addressed by the lowest zero bit of the index.
//             That vector is XOR-ed into each dimension's state, which yields
//             Gray-code-ordered Sobol samples. Each dimension keeps its own
//             writable table of direction vectors. Samples are offered over a
//             valid/ready handshake, and a flag marks the end of the period.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iClk     in   clock
//    iRstN    in   asynchronous active-low reset
//    iEn      in   run request (IDLE -> RUN, RUN -> IDLE when low)
//    iClr     in   synchronous restart of the sequence (index and state to 0)
//    iReady   in   consumer accepts the current sample
//    iWrEn    in   direction-vector write strobe
//    iWrDim   in   dimension being written
//    iWrIdx   in   vector index being written
//    iWrData  in   vector value
//    oValid   out  oRand/oIdx/oLast hold a valid sample
//    oRand    out  samples; dimension d at [(d+1)*BITWIDTH-1 : d*BITWIDTH]
//    oIdx     out  sequence index of the held sample
//    oLast    out  held sample is the last one of the 2^BITWIDTH period
// ============================================================================
module sobolrng_multi #(
    parameter int  BITWIDTH = 8,
    parameter int  NUM_DIM  = 2,
    localparam int DIMW     = (NUM_DIM  > 1) ? $clog2(NUM_DIM)  : 1,
    localparam int IDXW     = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic                        iEn,
    input  logic                        iClr,
    input  logic                        iReady,
    input  logic                        iWrEn,
    input  logic [DIMW-1:0]             iWrDim,
    input  logic [IDXW-1:0]             iWrIdx,
    input  logic [BITWIDTH-1:0]         iWrData,
    output logic                        oValid,
    output logic [NUM_DIM*BITWIDTH-1:0] oRand,
    output logic [BITWIDTH-1:0]         oIdx,
    output logic                        oLast
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [BITWIDTH-1:0]   cnt;
    logic [BITWIDTH-1:0]   x    [NUM_DIM];
    logic [BITWIDTH-1:0]   vec  [NUM_DIM][BITWIDTH];
    logic [BITWIDTH-1:0]   mask [NUM_DIM];
    logic [BITWIDTH-1:0]   onehot;
    logic                  fire;
    logic                  cnt_full;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // iClr only restarts the sequence; it blocks the IDLE->RUN start but
    // never forces RUN back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iEn && !iClr) state_nxt = RUN;
            RUN:     if (!iEn)         state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    assign fire     = (state == RUN) && iReady;
    assign cnt_full = &cnt;

    // Lowest zero bit of the index; all zeros when the index is all ones.
    assign onehot = ~cnt & (cnt + BITWIDTH'(1));

    // Vector selected by the one-hot for each dimension (read before any
    // write landing on the same edge, since the table is a register).
    always_comb begin
        for (int d = 0; d < NUM_DIM; d++) begin
            mask[d] = '0;
            for (int i = 0; i < BITWIDTH; i++) begin
                if (onehot[i]) begin
                    mask[d] = mask[d] | vec[d][i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction-vector table. Resets to van der Corput vectors. A write
    // only hits when both select fields decode to an existing entry, so
    // out-of-range addresses fall through with no effect.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int d = 0; d < NUM_DIM; d++) begin
                for (int i = 0; i < BITWIDTH; i++) begin
                    vec[d][i] <= BITWIDTH'(1) << (BITWIDTH - 1 - i);
                end
            end
        end else if (iWrEn) begin
            for (int d = 0; d < NUM_DIM; d++) begin
                for (int i = 0; i < BITWIDTH; i++) begin
                    if (iWrDim == DIMW'(d) && iWrIdx == IDXW'(i)) begin
                        vec[d][i] <= iWrData;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Index counter and per-dimension Sobol state. Clear wins over an
    // advance. Advancing from the all-ones index restarts at x_0.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt <= '0;
            for (int d = 0; d < NUM_DIM; d++) begin
                x[d] <= '0;
            end
        end else if (iClr) begin
            cnt <= '0;
            for (int d = 0; d < NUM_DIM; d++) begin
                x[d] <= '0;
            end
        end else if (fire) begin
            if (cnt_full) begin
                cnt <= '0;
                for (int d = 0; d < NUM_DIM; d++) begin
                    x[d] <= '0;
                end
            end else begin
                cnt <= cnt + BITWIDTH'(1);
                for (int d = 0; d < NUM_DIM; d++) begin
                    x[d] <= x[d] ^ mask[d];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registers
    // ------------------------------------------------------------------
    for (genvar d = 0; d < NUM_DIM; d++) begin : g_out
        assign oRand[d*BITWIDTH +: BITWIDTH] = x[d];
    end

    assign oValid = (state == RUN);
    assign oIdx   = cnt;
    assign oLast  = cnt_full;

endmodule
`default_nettype wire
